// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number arbiter and its generator.
package rng_pkg;

  localparam int              RNG_W         = 5;
  localparam int              MAX_TRIES_DEF = 8;
  localparam logic [RNG_W-1:0] RNG_SEED     = 5'h1f;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rng.sv
// Free-running 5-bit maximal-length LFSR (x^5 + x^3 + 1), period 31, never zero.
module rng
  import rng_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [RNG_W-1:0] d
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) d <= RNG_SEED;
    else       d <= {d[3:0], d[4] ^ d[2]};
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out bounded random values from a shared LFSR.
//   state    | meaning
//   ST_IDLE  | wait for any request, pick next round-robin
//   ST_GRANT | latch requester limit, clear try counter
//   ST_DRAW  | compare draw against limit, retry or fall back
//   ST_DONE  | one-cycle ack with result, update last-served pointer
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][RNG_W-1:0] limit,
  output logic [NREQ-1:0]            ack,
  output logic [RNG_W-1:0]           rnd,
  output logic                       busy,
  output logic [2:0]                 gnt_id
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [RNG_W-1:0] d;
  logic [RNG_W-1:0] lim_q, lim_nxt, lim_sel;
  logic [RNG_W-1:0] rnd_q, rnd_nxt;
  logic [2:0]       gnt_q, gnt_nxt;
  logic [2:0]       last_q, last_nxt;
  logic [TW-1:0]    tries_q, tries_nxt;
  logic [2:0]       pick;
  logic             any;
  int               idx;

  rng u_rng (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d)
  );

  // Walk downward so the nearest index after last_q wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = int'(last_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx[IW-1:0]]) begin
        pick = 3'(idx);
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    lim_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == 3'(i)) lim_sel = limit[i];
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    lim_nxt   = lim_q;
    tries_nxt = tries_q;
    rnd_nxt   = rnd_q;
    last_nxt  = last_q;
    case (state)
      ST_IDLE: begin
        if (any) begin
          gnt_nxt   = pick;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        lim_nxt   = lim_sel;
        tries_nxt = '0;
        state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        if (d <= lim_q) begin
          rnd_nxt   = d;
          state_nxt = ST_DONE;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          // Masking with the limit can never exceed it, so the result stays in range.
          tries_nxt = tries_q + 1'b1;
          rnd_nxt   = d & lim_q;
          state_nxt = ST_DONE;
        end else begin
          tries_nxt = tries_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_nxt  = gnt_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= ST_IDLE;
      gnt_q   <= '0;
      lim_q   <= '0;
      tries_q <= '0;
      rnd_q   <= '0;
      last_q  <= 3'(NREQ - 1);
    end else begin
      state   <= state_nxt;
      gnt_q   <= gnt_nxt;
      lim_q   <= lim_nxt;
      tries_q <= tries_nxt;
      rnd_q   <= rnd_nxt;
      last_q  <= last_nxt;
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = (state == ST_DONE) && (gnt_q == 3'(i));
    end
  end

  assign rnd    = (state == ST_DONE) ? rnd_q : '0;
  assign busy   = (state != ST_IDLE);
  assign gnt_id = (state == ST_IDLE) ? 3'd0 : gnt_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: a reference LFSR plus arbitration model predicts every ack.
module tb_rng_arbiter;

  localparam int NREQ = 4;
  localparam int MT   = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][4:0]  limit;
  logic [NREQ-1:0]       ack;
  logic [4:0]            rnd;
  logic                  busy;
  logic [2:0]            gnt_id;

  rng_arbiter #(.NREQ(NREQ), .MAX_TRIES(MT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .limit  (limit),
    .ack    (ack),
    .rnd    (rnd),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int rnd;
    int at;
    int start;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  logic [4:0]      m_lfsr;
  logic [1:0]      ptr;
  logic [NREQ-1:0] keep;
  int              long_model, long_seen, last_lat, max_rnd;

  function automatic logic [4:0] lfsr_step(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) m_lfsr <= 5'h1f;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at the negedge of an IDLE cycle right after req is raised.
  task automatic predict(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] hold, input int nsvc);
    int              t, tries, r;
    logic [4:0]      v, lim;
    logic [NREQ-1:0] pend;
    logic [1:0]      id, j;
    bit              found;
    exp_t            e;
    t = cyc;
    v = m_lfsr;
    pend = mask;
    for (int s = 0; s < nsvc; s++) begin
      found = 1'b0;
      id = '0;
      for (int i = 1; i <= NREQ; i++) begin
        j = ptr + 2'(i);
        if (!found && pend[j]) begin
          id = j;
          found = 1'b1;
        end
      end
      if (!found) break;
      e.start = t;
      lim = limit[id];
      v = lfsr_step(lfsr_step(v));
      t = t + 2;
      tries = 0;
      r = 0;
      forever begin
        if (v <= lim) begin
          r = v;
          break;
        end
        tries++;
        if (tries == MT) begin
          r = int'(v & lim);
          break;
        end
        v = lfsr_step(v);
        t++;
      end
      e.id  = int'(id);
      e.rnd = r;
      e.at  = t + 1;
      if (e.at - e.start == MT + 2) long_model++;
      sb.push_back(e);
      ptr = id;
      if (!hold[id]) pend[id] = 1'b0;
      t = t + 2;
      v = lfsr_step(lfsr_step(v));
    end
  endtask

  task automatic tick();
    exp_t e;
    int   id;
    id = 0;
    @(negedge clk);
    if (!rst_n) begin
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
        chk("ack_onehot", $countones(ack), 1);
        chk("busy_done", busy, 1);
        if (sb.size() == 0) begin
          chk("unexpected_ack", ack, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_id", id, e.id);
          chk("gnt_id", gnt_id, e.id);
          chk("rnd", rnd, e.rnd);
          chk("ack_cycle", cyc, e.at);
          last_lat = cyc - e.start;
          if (last_lat == MT + 2) long_seen++;
          if (int'(rnd) > max_rnd) max_rnd = int'(rnd);
        end
        for (int i = 0; i < NREQ; i++) if (ack[i] && !keep[i]) req[i] = 1'b0;
      end else begin
        chk("rnd_noack", rnd, 0);
      end
      if (!busy) chk("gnt_idle", gnt_id, 0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    req   = '0;
    keep  = '0;
    sb.delete();
    ptr   = 2'(NREQ - 1);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] m;
    int              n;
    req   = '0;
    limit = {NREQ{5'd31}};
    keep  = '0;
    long_model = 0;
    long_seen  = 0;
    last_lat   = 0;
    max_rnd    = 0;
    ptr        = 2'(NREQ - 1);
    do_reset();

    // Single requester, always-accept limit: minimum latency.
    tick();
    req[0] = 1'b1;
    predict(4'b0001, '0, 1);
    drain(40);
    chk("lat_min", last_lat, 3);

    // All four at once after reset: round-robin 0,1,2,3.
    do_reset();
    tick();
    req = 4'hf;
    predict(4'hf, '0, 4);
    drain(80);

    // Limit 0 forces the fallback path.
    tick();
    limit[2] = 5'd0;
    req[2] = 1'b1;
    predict(4'b0100, '0, 1);
    drain(40);
    chk("l0_lat_bound", int'(last_lat <= MT + 3), 1);

    // Limit changed after GRANT must not influence the draw.
    limit = {NREQ{5'd3}};
    tick();
    req[0] = 1'b1;
    predict(4'b0001, '0, 1);
    tick();
    tick();
    limit[0] = 5'd31;
    drain(40);

    // 200 requests with limit 3.
    limit = {NREQ{5'd3}};
    long_model = 0;
    long_seen  = 0;
    max_rnd    = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      req[k % NREQ] = 1'b1;
      m = '0;
      m[k % NREQ] = 1'b1;
      predict(m, '0, 1);
      drain(40);
    end
    chk("max_rnd_le3", int'(max_rnd <= 3), 1);
    chk("long_draw_cnt", long_seen, long_model);

    // Random masks and limits.
    for (int k = 0; k < 40; k++) begin
      tick();
      for (int i = 0; i < NREQ; i++) limit[i] = 5'($urandom_range(0, 31));
      m = 4'($urandom_range(1, 15));
      req = m;
      predict(m, '0, $countones(m));
      drain(200);
    end

    // Reset during DRAW aborts the request; req[1] is then served normally.
    do_reset();
    tick();
    limit = {NREQ{5'd0}};
    req[1] = 1'b1;
    repeat (3) tick();
    chk("draw_busy", busy, 1);
    do_reset();
    repeat (5) tick();
    limit = {NREQ{5'd31}};
    req[1] = 1'b1;
    predict(4'b0010, '0, 1);
    drain(40);

    // req[1] held, req[3] raised once: services 1,3,1.
    do_reset();
    tick();
    keep = 4'b0010;
    req  = 4'b1010;
    predict(4'b1010, 4'b0010, 3);
    n = 0;
    while (sb.size() > 1 && n < 60) begin
      tick();
      n++;
    end
    keep = '0;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
